// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package rr_arb_pkg;

  // Widest requester vector supported; the helpers work on this width.
  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

  // One-hot to binary index. Input must be one-hot or zero.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] v, input int n);
    logic [MAX_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        if (i == n - 1) r[0] = v[i];
        else            r[(i + 1) % MAX_REQ] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_ring.sv
// One-hot rotating priority pointer plus wrapped first-set search.
// Latency: winner is combinational from mask/pointer; pointer loads on the next edge.
// Backpressure: none; the caller decides when to load.
module rr_prio_ring
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_REQ-1:0] mask,
  input  logic             load,
  input  logic [N_REQ-1:0] load_val,
  output logic [N_REQ-1:0] win
);

  logic [N_REQ-1:0] ptr;
  logic [N_REQ-1:0] hi;

  // Pointer register: requester 0 has top priority out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    ptr <= N_REQ'(1);
    else if (load) ptr <= load_val;
  end

  // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
  always_comb begin
    hi  = mask & ~(ptr - N_REQ'(1));
    win = '0;
    if (|hi) win = hi & (~hi + N_REQ'(1));
    else     win = mask & (~mask + N_REQ'(1));
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-while-requesting grants; optional hold limit under RR_ARB_TIMEOUT_EN.
// Latency: one cycle from req to registered gnt; release hands over on the same edge.
// Backpressure: owner keeps gnt while its req is high; others wait (or pre-empt after MAX_HOLD when enabled).
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  rr_state_t            state;
  logic [N_REQ-1:0]     others;
  logic [N_REQ-1:0]     win;
  logic [N_REQ-1:0]     ptr_nxt;
  logic                 owner_req;
  logic                 any_other;
  logic                 ptr_load;
  logic                 revoke;
  logic [MAX_REQ-1:0]   rot_full;
  logic [MAX_IDX_W-1:0] idx_full;
  logic [IDX_W-1:0]     win_idx;
  logic                 unused_bits;

  // The current owner is never a candidate; in IDLE gnt is zero so this is just req.
  assign others    = req & ~gnt;
  assign owner_req = |(req & gnt);
  assign any_other = |others;

  assign rot_full    = rotl1(MAX_REQ'(win), N_REQ);
  assign ptr_nxt     = rot_full[N_REQ-1:0];
  assign idx_full    = onehot_to_idx(MAX_REQ'(win));
  assign win_idx     = idx_full[IDX_W-1:0];
  assign unused_bits = ^{rot_full, idx_full};

`ifdef RR_ARB_TIMEOUT_EN
  // hold_cnt counts completed cycles of the current tenure; CNT_LAST marks the final allowed one.
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign revoke  = (state == GRANT) && owner_req && any_other && (hold_cnt == CNT_LAST);
  assign timeout = timeout_q;
`else
  localparam int unused_max_hold = MAX_HOLD;

  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  // A new owner is installed from IDLE, on release with others waiting, or on revoke.
  assign ptr_load = any_other && ((state == IDLE) || !owner_req || revoke);

  rr_prio_ring #(
    .N_REQ (N_REQ)
  ) u_ring (
    .clk      (clk),
    .n_rst    (n_rst),
    .mask     (others),
    .load     (ptr_load),
    .load_val (ptr_nxt),
    .win      (win)
  );

  // Grant FSM with registered outputs and optional tenure counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= revoke;
`endif
      if (ptr_load) begin
        state     <= GRANT;
        gnt       <= win;
        gnt_valid <= 1'b1;
        gnt_idx   <= win_idx;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt  <= '0;
`endif
      end else begin
        case (state)
          GRANT: begin
            if (!owner_req) begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              gnt_idx   <= '0;
            end
`ifdef RR_ARB_TIMEOUT_EN
            else if (hold_cnt != CNT_LAST) begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N_REQ=4, MAX_HOLD=4): directed scenarios plus random traffic.
// Outputs are compared every falling edge against a behavioural model tracking owner index and pointer.
// Drives inputs on the falling edge; the model samples req on the rising edge like the DUT.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         timeout;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: owner index (-1 = none), priority index, tenure in cycles, timeout pulse.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_cnt   = 0;
  logic m_to    = 1'b0;

  rr_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // First requester at or after position p, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (m[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // Behavioural model of the arbitration rules.
  always @(posedge clk or negedge n_rst) begin
    logic [N-1:0] oh;
    logic [N-1:0] oth;
    int           w;
    if (!n_rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      oh   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      oth  = req & ~oh;
      if (m_owner >= 0 && (req & oh) != 0) begin
`ifdef RR_ARB_TIMEOUT_EN
        if (m_cnt >= MAX_HOLD && oth != 0) begin
          w       = pick(oth, m_ptr);
          m_owner = w;
          m_ptr   = (w + 1) % N;
          m_cnt   = 1;
          m_to    = 1'b1;
        end else if (m_cnt < MAX_HOLD) begin
          m_cnt++;
        end
`endif
      end else if (oth != 0) begin
        w       = pick(oth, m_ptr);
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = 1;
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("model_gnt",       gnt,       eg);
    check("model_gnt_valid", gnt_valid, m_owner >= 0);
    check("model_gnt_idx",   gnt_idx,   (m_owner < 0) ? 0 : m_owner);
    check("model_timeout",   timeout,   m_to);
  end

  initial begin
    req   = '0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_gnt",     gnt,     4'b0000);
    check("reset_idx",     gnt_idx, 2'd0);
    check("reset_timeout", timeout, 1'b0);

    // Single request after reset, then pointer favours requester 3.
    n_rst = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    check("single_gnt", gnt,     4'b0100);
    check("single_idx", gnt_idx, 2'd2);
    req = 4'b1001;
    @(negedge clk);
    check("ptr_after_2", gnt, 4'b1000);
    req = 4'b0000;
    @(negedge clk);
    check("idle_after_release", gnt_valid, 1'b0);

    // Full contention: each owner holds 2 cycles then drops for one.
    req = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("rr_order_idx",   gnt_idx,   i % 4);
      check("rr_order_valid", gnt_valid, 1'b1);
      @(negedge clk);
      check("rr_hold_valid", gnt_valid, 1'b1);
      req = 4'b1111 & ~gnt;
      @(negedge clk);
      req = 4'b1111;
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Wrap-around: owner 3 releases while 0 and 1 wait.
    req = 4'b1000;
    @(negedge clk);
    check("wrap_owner3", gnt, 4'b1000);
    req = 4'b0011;
    @(negedge clk);
    check("wrap_0", gnt, 4'b0001);
    req = 4'b0010;
    @(negedge clk);
    check("wrap_1", gnt, 4'b0010);

`ifndef RR_ARB_TIMEOUT_EN
    // No pre-emption: owner 1 keeps the grant while req[0] rises.
    req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_preempt", gnt, 4'b0010);
    end
`else
    // Hold limit: owner 0 revoked after 4 cycles in favour of 2.
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    check("hold_first", gnt, 4'b0001);
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_keep",    gnt,     4'b0001);
      check("hold_no_tout", timeout, 1'b0);
    end
    @(negedge clk);
    check("hold_revoked", gnt,     4'b0100);
    check("hold_pulse",   timeout, 1'b1);
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("sole_keep",    gnt,     4'b0100);
      check("sole_no_tout", timeout, 1'b0);
    end
`endif
    req = 4'b0000;
    @(negedge clk);

    // Async reset in the middle of a grant.
    req = 4'b1010;
    @(negedge clk);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("async_gnt_drop",   gnt,       4'b0000);
    check("async_valid_drop", gnt_valid, 1'b0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rearb_from_0", gnt, 4'b0010);

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2 n_rst = 1'b0;
        #2 n_rst = 1'b1;
      end
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
